// File: rtl/riio_bias_pkg.sv
// Shared types and constants for the EG1D80V bias/bandgap sequencer.
package riio_bias_pkg;

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_STARTUP    = 3'd1,
        ST_WAIT_VALID = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_RAMP       = 3'd4,
        ST_READY      = 3'd5,
        ST_FAULT      = 3'd6
    } state_t;

    localparam int unsigned TRIM_BIAS_W = 4;
    localparam int unsigned TRIM_CURV_W = 5;
    localparam int unsigned TRIM_VBG_W  = 5;

    // One spare bit above the largest terminal count so no counter can wrap.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/riio_sync2.sv
// Two-flop synchronizer with a selectable reset value.
module riio_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/riio_bias_seq_ctrl.sv
// Power-up sequencer for the bias/bandgap macro: kick, wait for valid, settle,
// staggered channel ramp, with retry-then-fault on timeout or loss of valid.
module riio_bias_seq_ctrl
    import riio_bias_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned STARTUP_CYC = 8,
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned STAGGER_CYC = 4,
    parameter int unsigned TIMEOUT_CYC = 32,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic                   EN_I,
    input  logic [TRIM_BIAS_W-1:0] TRIM_BIAS_I,
    input  logic [TRIM_CURV_W-1:0] TRIM_CURV_I,
    input  logic [TRIM_VBG_W-1:0]  TRIM_VBG_I,
    input  logic [N_CH-1:0]        CH_EN_I,
    input  logic                   BG_VALID_N_I,
    output logic                   BIAS_EN_O,
    output logic                   BG_STARTUP_O,
    output logic [TRIM_BIAS_W-1:0] TRIM_BIAS_O,
    output logic [TRIM_CURV_W-1:0] TRIM_CURV_O,
    output logic [TRIM_VBG_W-1:0]  TRIM_VBG_O,
    output logic [N_CH-1:0]        VBIAS_EN_O,
    output logic                   READY_O,
    output logic                   FAULT_O,
    output logic [2:0]             STATE_O
);

    localparam int unsigned CW = cnt_width(STARTUP_CYC, SETTLE_CYC, STAGGER_CYC, TIMEOUT_CYC);
    localparam int unsigned SW = cnt_width(N_CH, 1, 1, 1);

    localparam logic [CW-1:0] STARTUP_LAST = CW'(STARTUP_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [SW-1:0] SLOT_LAST    = SW'(N_CH - 1);
    localparam logic [SW-1:0] SLOT_ONE     = SW'(1);
    localparam logic [2:0]    RETRY_LIM    = 3'(MAX_RETRY);

    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [SW-1:0]          slot, slot_n, slot_inc;
    logic [2:0]             retry, retry_n;
    logic [N_CH-1:0]        vbias_n;
    logic [TRIM_BIAS_W-1:0] trim_bias_n;
    logic [TRIM_CURV_W-1:0] trim_curv_n;
    logic [TRIM_VBG_W-1:0]  trim_vbg_n;
    logic                   bg_valid_n_s;
    logic                   valid;
    logic                   fail;

    riio_sync2 #(.RST_VAL(1'b1)) u_valid_sync (
        .clk (CLK_I),
        .rst (RST_I),
        .d   (BG_VALID_N_I),
        .q   (bg_valid_n_s)
    );

    assign valid    = ~bg_valid_n_s;
    assign slot_inc = slot + SLOT_ONE;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt + CNT_ONE;
        slot_n      = slot;
        retry_n     = retry;
        vbias_n     = VBIAS_EN_O;
        trim_bias_n = TRIM_BIAS_O;
        trim_curv_n = TRIM_CURV_O;
        trim_vbg_n  = TRIM_VBG_O;
        fail        = 1'b0;

        case (state)
            ST_OFF: begin
                cnt_n = '0;
                if (EN_I) begin
                    state_n     = ST_STARTUP;
                    retry_n     = '0;
                    trim_bias_n = TRIM_BIAS_I;
                    trim_curv_n = TRIM_CURV_I;
                    trim_vbg_n  = TRIM_VBG_I;
                end
            end
            ST_STARTUP: begin
                if (cnt == STARTUP_LAST) begin
                    state_n = ST_WAIT_VALID;
                    cnt_n   = '0;
                end
            end
            ST_WAIT_VALID: begin
                if (valid) begin
                    state_n = ST_SETTLE;
                    cnt_n   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    fail = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!valid) begin
                    fail = 1'b1;
                end else if (cnt == SETTLE_LAST) begin
                    state_n    = ST_RAMP;
                    cnt_n      = '0;
                    slot_n     = '0;
                    vbias_n[0] = CH_EN_I[0];
                end
            end
            ST_RAMP: begin
                if (!valid) begin
                    fail = 1'b1;
                end else if (cnt == STAGGER_LAST) begin
                    cnt_n = '0;
                    if (slot == SLOT_LAST) begin
                        state_n = ST_READY;
                        vbias_n = CH_EN_I;
                    end else begin
                        slot_n = slot_inc;
                        for (int unsigned k = 0; k < N_CH; k++) begin
                            if (slot_inc == SW'(k)) vbias_n[k] = CH_EN_I[k];
                        end
                    end
                end
            end
            ST_READY: begin
                cnt_n   = '0;
                vbias_n = CH_EN_I;
                if (!valid) fail = 1'b1;
            end
            ST_FAULT: begin
                cnt_n = '0;
            end
            default: begin
                state_n = ST_OFF;
                cnt_n   = '0;
            end
        endcase

        // Timeout and loss of valid share one exit path: retry or give up.
        if (fail) begin
            vbias_n = '0;
            cnt_n   = '0;
            if (retry < RETRY_LIM) begin
                retry_n = retry + 3'd1;
                state_n = ST_STARTUP;
            end else begin
                state_n = ST_FAULT;
            end
        end

        if (!EN_I) begin
            state_n     = ST_OFF;
            cnt_n       = '0;
            slot_n      = '0;
            retry_n     = '0;
            vbias_n     = '0;
            trim_bias_n = '0;
            trim_curv_n = '0;
            trim_vbg_n  = '0;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state        <= ST_OFF;
            cnt          <= '0;
            slot         <= '0;
            retry        <= '0;
            VBIAS_EN_O   <= '0;
            TRIM_BIAS_O  <= '0;
            TRIM_CURV_O  <= '0;
            TRIM_VBG_O   <= '0;
            BIAS_EN_O    <= 1'b0;
            BG_STARTUP_O <= 1'b0;
            READY_O      <= 1'b0;
            FAULT_O      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            slot         <= slot_n;
            retry        <= retry_n;
            VBIAS_EN_O   <= vbias_n;
            TRIM_BIAS_O  <= trim_bias_n;
            TRIM_CURV_O  <= trim_curv_n;
            TRIM_VBG_O   <= trim_vbg_n;
            BIAS_EN_O    <= (state_n != ST_OFF) && (state_n != ST_FAULT);
            BG_STARTUP_O <= (state_n == ST_STARTUP);
            READY_O      <= (state_n == ST_READY);
            FAULT_O      <= (state_n == ST_FAULT);
        end
    end

    assign STATE_O = state;

endmodule
